axi_output_pack_fifo: RTL and testbench
=======================================

Name: axi_output_pack_fifo

Overview:
- Parametrised successor to the fixed 8-to-32 output FIFO. It packs a narrow producer stream (e.g. SHAKE/sampler bytes) into AXI-width words and buffers them in a DEPTH-entry FIFO.
- Words are drained on the AXI read-data channel as length-controlled bursts with a correct RVALID/RREADY/RLAST handshake.
- Adds backpressure, partial-word flush, runtime burst length and occupancy reporting. Single clock domain, placed between the hash core and the AXI slave read path.

Parameters:
- IN_W, 8, producer lane width in bits.
- OUT_W, 32, AXI data width; must be an integer multiple of IN_W.
- DEPTH, 16, FIFO words; power of 2, minimum 2.
- LEN_W, 4, width of burst_len (AXI ARLEN style, beats minus 1).

Ports:
- ACLK  in  1  clock, all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush of FIFO, packer and FSM.
- in_valid  in  1  producer lane valid.
- in_ready  out  1  producer lane accepted when in_valid && in_ready.
- in_data  in  IN_W  producer lane.
- in_last  in  1  final lane of the message; forces a partial-word push.
- burst_start  in  1  request one read burst.
- burst_len  in  LEN_W  beats minus 1, sampled with burst_start.
- burst_busy  out  1  burst accepted and not yet completed.
- burst_done  out  1  one-cycle pulse on the final beat handshake.
- RVALID  out  1  AXI read-data valid.
- RREADY  in  1  AXI read-data ready.
- RDATA  out  OUT_W  AXI read data.
- RLAST  out  1  final beat of the burst.
- level  out  $clog2(DEPTH)+1  stored word count.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.

Behaviour:
- Reset and clr values:
  - All outputs 0, except in_ready = 1 and empty = 1.
  - Pointers, lane counter, packing register and FSM all cleared.
  - clr has priority over every other event in the same cycle.
  - Reset or clr during a burst aborts it: RVALID drops immediately, no burst_done.
- Packing:
  - R = OUT_W/IN_W. The lane counter runs 0..R-1.
  - Lane k lands in bits [k*IN_W +: IN_W]; the first lane is least significant.
- Push:
  - A push happens on an accepted lane when lane == R-1 or in_last = 1.
  - The pushed word combines the stored lanes with the current lane, with unfilled upper lanes zero.
  - After a push the lane counter and packing register return to 0.
- in_ready = !full, a conservative rule that is independent of the lane counter.
  - Lanes are never lost and no push is ever attempted while full.
- FIFO storage:
  - Pointers are $clog2(DEPTH)+1 bits wide.
  - full when the MSBs differ and the remaining bits are equal; empty when the pointers are equal.
  - Pointers wrap naturally at 2*DEPTH.
  - Simultaneous push and pop: both pointers advance and level is unchanged. Pop while empty cannot occur (RVALID = 0).
- Read FSM:
  - IDLE:
    - burst_start loads beats_left = burst_len and moves to BURST. burst_busy = 1 from the next cycle.
    - burst_start while not IDLE is ignored.
  - BURST:
    - RVALID = !empty. RDATA = mem[rptr], read combinationally. RLAST = RVALID && beats_left == 0.
    - On RVALID && RREADY: pop, then decrement beats_left.
    - If RLAST was set on that beat: pulse burst_done and return to IDLE.
  - Once RVALID rises it stays high, with RDATA and RLAST stable, until RREADY. This holds because only a pop can empty the FIFO.
  - In BURST with an empty FIFO, RVALID = 0 and the FSM waits indefinitely. There is no timeout.
- Latency: a word pushed in cycle N is visible on RDATA/RVALID in cycle N+1 when BURST is already active.
- level/full/empty are registered and consistent with the pointers every cycle.

Decomposition:
- Shared package:
  - read FSM state encoding (IDLE, BURST);
  - helper function for the pointer width;
  - elaboration-time check on OUT_W % IN_W == 0 and DEPTH being a power of 2.
- One sub-module, axi_sync_fifo_mem: the DEPTH x OUT_W register array with write port and asynchronous read port, reusable by the input-side FIFO.
- The packer and FSM stay in the top level.

Test Plan:
- Defaults; feed bytes 01,02,...,08 back-to-back; burst_len=1; RREADY=1 -> RDATA 0x04030201 then 0x08070605, RLAST on beat 2, burst_done one cycle, level returns to 0.
- Feed 3 bytes AA,BB,CC with in_last on CC -> one word 0x00CCBBAA pushed, lane counter back to 0.
- Fill 16 words with no burst -> full = 1, in_ready = 0, level = 16. Extra in_valid for 10 cycles changes nothing; first word intact afterwards.
- burst_len=3, RREADY toggling 1,0,0,1... -> RDATA/RVALID held during stalls, exactly 4 pops, RLAST only on the 4th beat. burst_start issued mid-burst is ignored.
- Burst started on an empty FIFO, words trickling in every 5 cycles -> RVALID low until each arrives. Push and pop in the same cycle keep level constant.
- Assert ARESETn low mid-burst, then separately pulse clr mid-burst -> RVALID = 0, level = 0, FSM in IDLE, no burst_done. The next full burst is correct.

Source files
------------

// File: rtl/axi_output_pack_fifo_pkg.sv
// Shared definitions for the narrow-to-AXI packing FIFO: read FSM states,
// pointer width helper and a parameter sanity function.
package axi_output_pack_fifo_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_state_e;

  // One extra MSB beyond the address lets full and empty be told apart.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit cfg_ok(input int in_w, input int out_w, input int depth);
    return (in_w > 0) && (out_w % in_w == 0) && (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/axi_sync_fifo_mem.sv
// DEPTH x W register array with one synchronous write port and one
// asynchronous read port; shared by the input- and output-side FIFOs.
module axi_sync_fifo_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset: a slot is only read after it
  // has been written, so reset would just add fan-out to every storage bit.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axi_output_pack_fifo.sv
// Packs an IN_W producer lane stream into OUT_W words, buffers them in a
// DEPTH-word FIFO and drains them as length-controlled AXI read bursts.
module axi_output_pack_fifo
  import axi_output_pack_fifo_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32,
  parameter int DEPTH = 16,
  parameter int LEN_W = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        clr,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_W-1:0]             in_data,
  input  logic                        in_last,
  input  logic                        burst_start,
  input  logic [LEN_W-1:0]            burst_len,
  output logic                        burst_busy,
  output logic                        burst_done,
  output logic                        RVALID,
  input  logic                        RREADY,
  output logic [OUT_W-1:0]            RDATA,
  output logic                        RLAST,
  output logic [ptr_width(DEPTH)-1:0] level,
  output logic                        full,
  output logic                        empty
);

  localparam int R      = OUT_W / IN_W;
  localparam int LANE_W = (R > 1) ? $clog2(R) : 1;
  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int AW     = PTR_W - 1;

  if (!cfg_ok(IN_W, OUT_W, DEPTH)) begin : g_cfg_check
    $error("axi_output_pack_fifo: OUT_W must be a multiple of IN_W and DEPTH a power of 2 >= 2");
  end

  logic [LANE_W-1:0] lane;
  logic [OUT_W-1:0]  pack_q;
  logic [OUT_W-1:0]  push_word;
  logic [OUT_W-1:0]  rd_word;
  logic [PTR_W-1:0]  wptr, rptr, wptr_d, rptr_d;
  logic              accept, lane_end, push, pop;
  rd_state_e         state, state_d;
  logic [LEN_W-1:0]  beats_left, beats_d;

  // Conservative backpressure: a push can never hit a full FIFO.
  assign in_ready  = !full;
  assign accept    = in_valid && in_ready;
  assign lane_end  = (lane == LANE_W'(R - 1));
  assign push      = accept && (lane_end || in_last) && !clr;
  assign push_word = pack_q | (OUT_W'(in_data) << (IN_W * int'(lane)));

  axi_sync_fifo_mem #(
    .W     (OUT_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (ACLK),
    .we    (push),
    .waddr (wptr[AW-1:0]),
    .wdata (push_word),
    .raddr (rptr[AW-1:0]),
    .rdata (rd_word)
  );

  always_comb begin
    wptr_d = wptr + PTR_W'(push);
    rptr_d = rptr + PTR_W'(pop);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      lane   <= '0;
      pack_q <= '0;
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (clr) begin
      lane   <= '0;
      pack_q <= '0;
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (accept) begin
        if (lane_end || in_last) begin
          lane   <= '0;
          pack_q <= '0;
        end else begin
          lane   <= lane + LANE_W'(1);
          pack_q <= push_word;
        end
      end
      wptr  <= wptr_d;
      rptr  <= rptr_d;
      level <= wptr_d - rptr_d;
      full  <= (wptr_d[PTR_W-1] != rptr_d[PTR_W-1]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
      empty <= (wptr_d == rptr_d);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      beats_left <= '0;
    end else begin
      state      <= state_d;
      beats_left <= beats_d;
    end
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d    = state;
    beats_d    = beats_left;
    pop        = 1'b0;
    burst_done = 1'b0;
    RVALID     = 1'b0;
    RLAST      = 1'b0;
    case (state)
      IDLE: begin
        if (burst_start) begin
          state_d = BURST;
          beats_d = burst_len;
        end
      end
      BURST: begin
        RVALID = !empty;
        RLAST  = RVALID && (beats_left == '0);
        if (RVALID && RREADY) begin
          pop = 1'b1;
          if (RLAST) begin
            burst_done = 1'b1;
            state_d    = IDLE;
          end else begin
            beats_d = beats_left - LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A flush aborts any burst in flight without signalling completion.
    if (clr) begin
      state_d    = IDLE;
      beats_d    = '0;
      pop        = 1'b0;
      burst_done = 1'b0;
    end
  end

  assign burst_busy = (state == BURST);
  assign RDATA      = RVALID ? rd_word : '0;

endmodule

// File: tb/tb_axi_output_pack_fifo.sv
// Scoreboard bench for axi_output_pack_fifo: directed stimulus queues the
// expected beats, an independent monitor checks every read-data handshake.
module tb_axi_output_pack_fifo;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        burst_start = 1'b0;
  logic [3:0]  burst_len = '0;
  logic        burst_busy, burst_done;
  logic        RVALID, RLAST, full, empty;
  logic        RREADY = 1'b0;
  logic [31:0] RDATA;
  logic [4:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       sb_q[$];
  logic [31:0] exp_words[$];
  int          pop_cnt = 0;
  int          done_cnt = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d = '0;
  logic        hold_l = 1'b0;
  logic        clr_q = 1'b0;

  axi_output_pack_fifo dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .burst_start (burst_start),
    .burst_len   (burst_len),
    .burst_busy  (burst_busy),
    .burst_done  (burst_done),
    .RVALID      (RVALID),
    .RREADY      (RREADY),
    .RDATA       (RDATA),
    .RLAST       (RLAST),
    .level       (level),
    .full        (full),
    .empty       (empty)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  always @(posedge ACLK) clr_q <= clr;

  always @(negedge ACLK) begin : monitor
    beat_t b;
    if (!ARESETn || clr_q) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("hold_rvalid", 32'(RVALID), 32'd1);
        check("hold_rdata", RDATA, hold_d);
        check("hold_rlast", 32'(RLAST), 32'(hold_l));
      end
      if (RVALID && RREADY) begin
        pop_cnt++;
        if (sb_q.size() == 0) begin
          check("unexpected_beat", RDATA, 32'hFFFF_FFFF);
        end else begin
          b = sb_q.pop_front();
          check("rdata", RDATA, b.data);
          check("rlast", 32'(RLAST), 32'(b.last));
          check("burst_done", 32'(burst_done), 32'(b.last));
        end
      end else if (burst_done) begin
        check("stray_burst_done", 32'(burst_done), 32'd0);
      end
      if (burst_done) done_cnt++;
      hold_v = RVALID && !RREADY;
      hold_d = RDATA;
      hold_l = RLAST;
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_lane(input logic [7:0] d, input logic last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) check("lane_accept_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rec);
    for (int k = 0; k < 4; k++) send_lane(w[8*k +: 8], 1'b0);
    if (rec) exp_words.push_back(w);
  endtask

  task automatic start_burst(input logic [3:0] len);
    beat_t b;
    burst_start = 1'b1;
    burst_len   = len;
    for (int i = 0; i <= int'(len); i++) begin
      b.data = (exp_words.size() > 0) ? exp_words.pop_front() : 32'hDEAD_DEAD;
      b.last = (i == int'(len));
      sb_q.push_back(b);
    end
    tick();
    burst_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (burst_busy && t < 500) begin
      tick();
      t++;
    end
    if (burst_busy) check(name, 32'(burst_busy), 32'd0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_rvalid"}, 32'(RVALID), 32'd0);
    check({tag, "_level"}, 32'(level), 32'd0);
    check({tag, "_busy"}, 32'(burst_busy), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int pops0, done0;
    logic [31:0] w;

    // Reset values
    repeat (3) @(posedge ACLK);
    #1;
    check_cleared("in_reset");
    ARESETn = 1'b1;
    tick();
    check_cleared("post_reset");
    check("reset_full", 32'(full), 32'd0);
    check("reset_rlast", 32'(RLAST), 32'd0);
    check("reset_rdata", RDATA, 32'd0);
    check("reset_done", 32'(burst_done), 32'd0);

    // Bytes 01..08 back-to-back, two-beat burst
    for (int i = 1; i <= 8; i++) send_lane(8'(i), 1'b0);
    exp_words.push_back(32'h0403_0201);
    exp_words.push_back(32'h0807_0605);
    check("t1_level", 32'(level), 32'd2);
    done0 = done_cnt;
    pops0 = pop_cnt;
    RREADY = 1'b1;
    start_burst(4'd1);
    wait_idle("t1_timeout");
    check("t1_level_end", 32'(level), 32'd0);
    check("t1_pops", 32'(pop_cnt - pops0), 32'd2);
    check("t1_done", 32'(done_cnt - done0), 32'd1);

    // Partial word flush with in_last, then a full word to prove lane reset
    RREADY = 1'b0;
    send_lane(8'hAA, 1'b0);
    send_lane(8'hBB, 1'b0);
    send_lane(8'hCC, 1'b1);
    exp_words.push_back(32'h00CC_BBAA);
    check("t2_partial_level", 32'(level), 32'd1);
    send_word(32'h11FF_EEDD, 1'b1);
    check("t2_level", 32'(level), 32'd2);
    RREADY = 1'b1;
    start_burst(4'd1);
    wait_idle("t2_timeout");
    check("t2_level_end", 32'(level), 32'd0);

    // Fill to full, hammer in_valid, then drain all sixteen
    RREADY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(16 + 4 * i + k);
      send_word(w, 1'b1);
    end
    check("t3_full", 32'(full), 32'd1);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    check("t3_level", 32'(level), 32'd16);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (10) tick();
    in_valid = 1'b0;
    check("t3_level_hold", 32'(level), 32'd16);
    check("t3_full_hold", 32'(full), 32'd1);
    RREADY = 1'b1;
    start_burst(4'd15);
    wait_idle("t3_timeout");
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_level_end", 32'(level), 32'd0);

    // Stalled four-beat burst with an ignored mid-burst start
    RREADY = 1'b0;
    send_word(32'hDEAD_BEEF, 1'b1);
    send_word(32'hCAFE_F00D, 1'b1);
    send_word(32'h0123_4567, 1'b1);
    send_word(32'h89AB_CDEF, 1'b1);
    send_word(32'h5A5A_A5A5, 1'b1);
    pops0 = pop_cnt;
    done0 = done_cnt;
    start_burst(4'd3);
    for (int t = 0; t < 200 && burst_busy; t++) begin
      RREADY      = (t % 3 == 0);
      burst_start = (t == 2);
      burst_len   = 4'd0;
      tick();
    end
    burst_start = 1'b0;
    RREADY = 1'b0;
    check("t4_busy_end", 32'(burst_busy), 32'd0);
    check("t4_pops", 32'(pop_cnt - pops0), 32'd4);
    check("t4_done", 32'(done_cnt - done0), 32'd1);
    check("t4_level", 32'(level), 32'd1);
    repeat (2) tick();
    check("t4_no_rearm", 32'(burst_busy), 32'd0);
    RREADY = 1'b1;
    start_burst(4'd0);
    wait_idle("t4_drain_timeout");
    check("t4_level_end", 32'(level), 32'd0);

    // Burst on empty FIFO with words trickling in
    exp_words.push_back(32'h1020_3040);
    exp_words.push_back(32'h5060_7080);
    exp_words.push_back(32'h90A0_B0C0);
    done0 = done_cnt;
    RREADY = 1'b1;
    start_burst(4'd2);
    repeat (3) tick();
    check("t5_busy", 32'(burst_busy), 32'd1);
    send_word(32'h1020_3040, 1'b0);
    for (int i = 0; i < 2; i++) begin
      repeat (5) tick();
      check("t5_rvalid_gap", 32'(RVALID), 32'd0);
      send_word((i == 0) ? 32'h5060_7080 : 32'h90A0_B0C0, 1'b0);
    end
    wait_idle("t5_timeout");
    check("t5_done", 32'(done_cnt - done0), 32'd1);
    check("t5_level", 32'(level), 32'd0);

    // Push and pop on the same edge keep level constant
    RREADY = 1'b0;
    send_word(32'hA1A2_A3A4, 1'b1);
    send_word(32'hB1B2_B3B4, 1'b1);
    start_burst(4'd1);
    exp_words.push_back(32'hC1C2_C3C4);
    send_lane(8'hC4, 1'b0);
    send_lane(8'hC3, 1'b0);
    send_lane(8'hC2, 1'b0);
    check("t6_level_pre", 32'(level), 32'd2);
    in_valid = 1'b1;
    in_data  = 8'hC1;
    RREADY   = 1'b1;
    tick();
    in_valid = 1'b0;
    RREADY   = 1'b0;
    check("t6_level_same", 32'(level), 32'd2);
    RREADY = 1'b1;
    wait_idle("t6_timeout");
    check("t6_level_one", 32'(level), 32'd1);
    start_burst(4'd0);
    wait_idle("t6_drain_timeout");
    check("t6_level_end", 32'(level), 32'd0);

    // Asynchronous reset mid-burst
    RREADY = 1'b0;
    send_word(32'h1111_1111, 1'b1);
    send_word(32'h2222_2222, 1'b1);
    send_word(32'h3333_3333, 1'b1);
    start_burst(4'd2);
    tick();
    check("t7_rvalid_pre", 32'(RVALID), 32'd1);
    done0 = done_cnt;
    ARESETn = 1'b0;
    #2;
    check_cleared("t7_reset");
    sb_q.delete();
    exp_words.delete();
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    tick();
    check("t7_done", 32'(done_cnt - done0), 32'd0);
    check("t7_rvalid_post", 32'(RVALID), 32'd0);

    // clr mid-burst with a partially packed word pending
    send_word(32'h4444_4444, 1'b1);
    send_word(32'h5555_5555, 1'b1);
    send_lane(8'h77, 1'b0);
    start_burst(4'd1);
    tick();
    check("t8_rvalid_pre", 32'(RVALID), 32'd1);
    done0 = done_cnt;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_cleared("t8_clr");
    sb_q.delete();
    exp_words.delete();
    tick();
    check("t8_done", 32'(done_cnt - done0), 32'd0);

    // Full burst after the abort
    send_word(32'h0BAD_F00D, 1'b1);
    send_word(32'h600D_CAFE, 1'b1);
    RREADY = 1'b1;
    start_burst(4'd1);
    wait_idle("t9_timeout");
    check("t9_done", 32'(done_cnt - done0), 32'd1);
    check("t9_level", 32'(level), 32'd0);

    repeat (3) tick();
    check("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
